// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//
// Contents:
//   owner_e        owner tag carried down the response pipe (NONE/IF/D)
//   arb_state_e    arbitration mode (NORMAL: data wins, FORCE_IF: fetch wins)
//   MEM_LAT_MIN/MAX  legal memory read latency range
//   clamp_mem_lat  folds a latency parameter into the legal range
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    typedef enum logic {
        ARB_NORMAL   = 1'b0,
        ARB_FORCE_IF = 1'b1
    } arb_state_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    // Keeps the tag pipe depth sane if the arbiter is mis-parameterised.
    function automatic int clamp_mem_lat(input int lat);
        if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
        if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// Owner-tag shift register that tracks which port owns each in-flight read.
// A tag is pushed every cycle (OWN_NONE for writes and idle cycles), so the
// tag at the tail lines up with the memory's read data DEPTH cycles later.
//
// Ports:
//   clk       rising-edge clock
//   clr       asynchronous, active-high clear (all stages -> OWN_NONE)
//   push_tag  owner tag entering the pipe this cycle
//   tail_tag  owner tag of the data returning this cycle
module resp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] push_tag,
    output logic [1:0] tail_tag
);

    owner_e stage [DEPTH];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= OWN_NONE;
            end
        end else begin
            stage[0] <= owner_e'(push_tag);
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tail_tag = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified memory between instruction fetch (IF)
// and the data-memory port (D) of the 5-stage pipeline.
//
// Handshake: a port's req (with its address/data) is held until the cycle its
// gnt is high; that same cycle the access is driven onto mem_* and is done.
// Reads return on the owning port's rvalid exactly MEM_LAT cycles later, for
// one cycle, in issue order. Writes never produce an rvalid.
//
// Ports:
//   clk, reset                 clock, async active-high reset
//   if_req/if_addr             fetch read request
//   if_gnt/if_rvalid/if_rdata  fetch grant and read response
//   d_req/d_we/d_addr/d_wdata  data request (read or write)
//   d_gnt/d_rvalid/d_rdata     data grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (mirrors granted port)
//   mem_rdata                  memory read data, MEM_LAT cycles after issue
//   stall_if/stall_mem         requester denied this cycle (hazard unit)
//
// Arbitration state (state_q) and starve counter (starve_q) are plain
// registers at top level so checkers can bind to them directly.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              stall_if,
    output logic              stall_mem
);

    localparam int PIPE_DEPTH = clamp_mem_lat(MEM_LAT);
    localparam int CNT_W      = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             if_gnt_c, d_gnt_c;
    logic [1:0]       push_tag;
    logic [1:0]       tail_tag;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_NORMAL;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // ------------------------------------------------------------------
    // Grant selection, next state, starve counter
    // ------------------------------------------------------------------
    always_comb begin
        if_gnt_c = 1'b0;
        d_gnt_c  = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;

        // Grants are suppressed during reset so every output reads 0.
        if (!reset) begin
            if (if_req && d_req) begin
                // Data normally wins: it belongs to the older instruction.
                if (state_q == ARB_FORCE_IF) begin
                    if_gnt_c = 1'b1;
                end else begin
                    d_gnt_c = 1'b1;
                end
            end else begin
                if_gnt_c = if_req;
                d_gnt_c  = d_req;
            end
        end

        case (state_q)
            ARB_NORMAL: begin
                if (starve_q == CNT_MAX) begin
                    state_d = ARB_FORCE_IF;
                end
            end
            ARB_FORCE_IF: begin
                if (if_gnt_c) begin
                    state_d = ARB_NORMAL;
                end
            end
            default: state_d = ARB_NORMAL;
        endcase

        // Counts consecutive denied fetch cycles; saturates at the limit.
        if (if_gnt_c || !if_req) begin
            starve_d = '0;
        end else if (starve_q != CNT_MAX) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Memory command: mirrors whichever port holds the grant
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt_c) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt_c) begin
            mem_addr = if_addr;
        end
    end

    assign if_gnt    = if_gnt_c;
    assign d_gnt     = d_gnt_c;
    assign mem_en    = if_gnt_c | d_gnt_c;
    assign mem_we    = d_gnt_c & d_we;
    assign stall_if  = if_req & ~if_gnt_c & ~reset;
    assign stall_mem = d_req & ~d_gnt_c & ~reset;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    always_comb begin
        push_tag = OWN_NONE;
        if (if_gnt_c) begin
            push_tag = OWN_IF;
        end else if (d_gnt_c && !d_we) begin
            push_tag = OWN_D;
        end
    end

    resp_tag_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_tag_pipe (
        .clk      (clk),
        .clr      (reset),
        .push_tag (push_tag),
        .tail_tag (tail_tag)
    );

    assign if_rvalid = (tail_tag == OWN_IF);
    assign d_rvalid  = (tail_tag == OWN_D);

    // Read data is shared and unqualified; forced to 0 only under reset.
    assign if_rdata = reset ? '0 : mem_rdata;
    assign d_rdata  = reset ? '0 : mem_rdata;

endmodule
